// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide with architectural HI/LO; long ops commit MUL_CYCLES/DIV_CYCLES after accept, mthi/mtlo next edge.
// Never stalls: starts seen while busy or cancelled are dropped, the hazard unit stalls on busy|start.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, res_q, res_r, res_hi, res_lo;
    logic               is_div, is_sdiv, b_zero, accept, commit;

    // Result datapath works only from the captured operands, so it is a multi-cycle path.
    always_comb begin
        prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_sdiv = (op_q == OP_DIV);
        b_zero  = (b_q == '0);
        a_mag   = (is_sdiv && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag   = (is_sdiv && b_q[WIDTH-1]) ? -b_q : b_q;
        if (b_zero) b_mag = {{(WIDTH-1){1'b0}}, 1'b1};
        uq      = a_mag / b_mag;
        ur      = a_mag % b_mag;
        // Magnitude division then sign fix-up: truncates toward zero, remainder follows dividend.
        res_q   = (is_sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
        res_r   = (is_sdiv && a_q[WIDTH-1]) ? -ur : ur;
        res_hi  = '0;
        res_lo  = '0;
        case (op_q)
            OP_MULT:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
            OP_MULTU: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
            OP_DIV, OP_DIVU: begin
                res_hi = b_zero ? a_q : res_r;
                res_lo = b_zero ? '1  : res_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (cnt_q != '0);
        accept     = start & ~cancel & ~busy;
        commit     = (cnt_q == CW'(1));
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;
        if (busy) cnt_d = cnt_q - CW'(1);
        if (commit) begin
            hi_d       = res_hi;
            lo_d       = res_lo;
            div_zero_d = is_div & b_zero;
        end
        if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    cnt_d = CW'(MUL_CYCLES);
                    op_d  = op;
                    a_d   = rs;
                    b_d   = rt;
                end
                OP_DIV, OP_DIVU: begin
                    cnt_d = CW'(DIV_CYCLES);
                    op_d  = op;
                    a_d   = rs;
                    b_d   = rt;
                end
                OP_MTHI: hi_d = rs;
                OP_MTLO: lo_d = rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at default parameters and at WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, cancel, busy, div_zero;
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;

    logic        s_start, s_cancel, s_busy, s_div_zero;
    logic [2:0]  s_op;
    logic [15:0] s_rs, s_rt, s_hi, s_lo;

    int errs = 0;
    int checks = 0;
    int n;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    mul_div_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .cancel(s_cancel),
        .rs(s_rs), .rt(s_rt), .busy(s_busy), .hi(s_hi), .lo(s_lo), .div_zero(s_div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents the op for one cycle and returns at the next negedge.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        start = 1'b1; op = o; rs = a; rt = b; cancel = c;
        @(negedge clk);
        start = 1'b0; op = 3'b000; cancel = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    endtask

    task automatic launch16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic c);
        s_start = 1'b1; s_op = o; s_rs = a; s_rt = b; s_cancel = c;
        @(negedge clk);
        s_start = 1'b0; s_op = 3'b000; s_cancel = 1'b0;
    endtask

    task automatic wait_idle16(output int cnt);
        cnt = 0;
        while (s_busy && cnt < 40) begin cnt++; @(negedge clk); end
    endtask

    initial begin
        reset = 1'b1;
        start = 0; op = 0; cancel = 0; rs = 0; rt = 0;
        s_start = 0; s_op = 0; s_cancel = 0; s_rs = 0; s_rt = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", div_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // signed mult
        launch(3'b001, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_idle(n);
        chk("mult_cycles", n, 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        // multu then divu with no dead cycle
        launch(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle(n);
        chk("multu_cycles", n, 5);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        launch(3'b100, 32'd7, 32'd2, 1'b0);
        chk("divu_b2b_busy", busy, 1);
        chk("divu_stale_lo", lo, 32'hFFFF_FFFE);
        wait_idle(n);
        chk("divu_cycles", n, 10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        launch(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(n);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_neg_dz", div_zero, 0);

        launch(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        launch(3'b011, 32'd9, 32'd0, 1'b0);
        wait_idle(n);
        chk("div0_cycles", n, 10);
        chk("div0_hi", hi, 32'd9);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_dz", div_zero, 1);
        @(negedge clk);
        chk("div0_dz_pulse", div_zero, 0);

        // cancel suppresses launches and writes
        launch(3'b001, 32'd3, 32'd4, 1'b1);
        chk("cancel_mult_busy", busy, 0);
        @(negedge clk);
        chk("cancel_mult_hi", hi, 32'd9);
        chk("cancel_mult_lo", lo, 32'hFFFF_FFFF);
        launch(3'b101, 32'h55, 32'd0, 1'b1);
        chk("cancel_mthi", hi, 32'd9);
        launch(3'b110, 32'hABCD, 32'd0, 1'b0);
        chk("mtlo", lo, 32'hABCD);
        chk("mtlo_busy", busy, 0);
        launch(3'b101, 32'h77, 32'd0, 1'b0);
        chk("mthi", hi, 32'h77);

        // in-flight op survives cancel, ignores new starts and operand changes
        launch(3'b001, 32'd6, 32'd7, 1'b0);
        start = 1'b1; op = 3'b101; rs = 32'h1234; cancel = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'b001; rs = 32'd100; rt = 32'd100; cancel = 1'b0;
        @(negedge clk);
        start = 1'b0; op = 3'b000; rs = 32'hDEAD_BEEF; rt = 32'h1357_9BDF;
        chk("busy_hi_stale", hi, 32'h77);
        wait_idle(n);
        chk("busy_remaining", n, 3);
        chk("busy_mult_hi", hi, 32'h0);
        chk("busy_mult_lo", lo, 32'd42);
        repeat (6) @(negedge clk);
        chk("busy_no_relaunch", busy, 0);

        // asynchronous reset at busy cycle 3 of a div
        launch(3'b101, 32'h5555, 32'd0, 1'b0);
        launch(3'b011, 32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_dz", div_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("arst_no_commit_lo", lo, 0);
        chk("arst_no_commit_busy", busy, 0);

        // WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3
        launch16(3'b001, 16'hFFFD, 16'd5, 1'b0);
        wait_idle16(n);
        chk("w16_mult_cycles", n, 1);
        chk("w16_mult_hi", s_hi, 16'hFFFF);
        chk("w16_mult_lo", s_lo, 16'hFFF1);
        launch16(3'b010, 16'hFFFF, 16'd2, 1'b0);
        wait_idle16(n);
        chk("w16_multu_hi", s_hi, 16'h1);
        chk("w16_multu_lo", s_lo, 16'hFFFE);
        launch16(3'b100, 16'd7, 16'd2, 1'b0);
        wait_idle16(n);
        chk("w16_divu_cycles", n, 3);
        chk("w16_divu_lo", s_lo, 16'd3);
        chk("w16_divu_hi", s_hi, 16'd1);
        launch16(3'b011, 16'hFFF9, 16'd2, 1'b0);
        wait_idle16(n);
        chk("w16_div_neg_lo", s_lo, 16'hFFFD);
        chk("w16_div_neg_hi", s_hi, 16'hFFFF);
        launch16(3'b011, 16'h8000, 16'hFFFF, 1'b0);
        wait_idle16(n);
        chk("w16_div_ovf_lo", s_lo, 16'h8000);
        chk("w16_div_ovf_hi", s_hi, 16'h0);
        launch16(3'b011, 16'd9, 16'd0, 1'b0);
        wait_idle16(n);
        chk("w16_div0_hi", s_hi, 16'd9);
        chk("w16_div0_lo", s_lo, 16'hFFFF);
        chk("w16_div0_dz", s_div_zero, 1);
        @(negedge clk);
        chk("w16_div0_dz_pulse", s_div_zero, 0);
        launch16(3'b001, 16'd3, 16'd4, 1'b1);
        chk("w16_cancel_busy", s_busy, 0);
        @(negedge clk);
        chk("w16_cancel_lo", s_lo, 16'hFFFF);
        launch16(3'b011, 16'd100, 16'd7, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("w16_arst_busy", s_busy, 0);
        chk("w16_arst_hi", s_hi, 0);
        chk("w16_arst_lo", s_lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("w16_arst_no_commit", s_lo, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
